// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches, buffers up to two returned
// instructions, and flushes/drops stale traffic on a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic [31:0] q_pc_q    [2];
  logic [31:0] q_instr_q [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  drop_q, drop_d;

  logic        pop;
  logic        push;
  logic        accept;
  logic        rsp_live;
  logic        drop_rsp;
  logic [2:0]  occupancy;
  logic [31:0] target;

  // Handshake decode. Occupancy counts queued entries plus everything still in flight
  // (including responses that will be dropped), so a push always has a free slot.
  always_comb begin
    target         = redirect_pc & 32'hFFFF_FFFC;
    pop            = (count_q != 2'd0) && instr_ready;
    occupancy      = {1'b0, count_q} + {1'b0, outst_q} - {2'b00, pop};
    imem_req_valid = !rst && !redirect_valid && (occupancy < 3'd2);
    accept         = imem_req_valid && imem_req_ready;
    // A response with nothing in flight can only be a pre-reset leftover; ignore it.
    rsp_live       = imem_rsp_valid && (outst_q != 2'd0);
    drop_rsp       = rsp_live && (drop_q != 2'd0);
    push           = rsp_live && (drop_q == 2'd0) && !redirect_valid;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q + {1'b0, accept} - {1'b0, rsp_live};
    drop_d     = drop_q;

    if (redirect_valid) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
      // Every request not answered this cycle now belongs to the old path.
      drop_d     = outst_q - {1'b0, rsp_live};
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (drop_rsp) begin
        drop_d = drop_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      outst_q    <= 2'd0;
      drop_q     <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is reset so the head reads as zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        q_pc_q[i]    <= 32'd0;
        q_instr_q[i] <= 32'd0;
      end
    end else if (push) begin
      q_pc_q[wr_ptr_q]    <= rsp_pc_q;
      q_instr_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = q_instr_q[rd_ptr_q];
  assign instr_pc    = q_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural in-order memory, a program-order
// reference stream (pc advances by 4, jumps on redirect) and directed corner phases.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] XORV   = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int pops        = 0;

  // Scoreboard: start pc of each new program segment, pushed when a redirect is issued.
  logic [31:0] seg_q[$];

  int unsigned mem_lat     = 1;
  int unsigned mem_jit     = 0;
  int unsigned mem_rdy_pct = 100;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Behavioural instruction memory: in-order, latency >= 1, data = addr ^ XORV.
  initial begin
    logic        acc;
    logic        taken;
    logic [31:0] acc_addr;
    int unsigned acc_cyc;
    int unsigned due;
    int unsigned last_due;
    mreq_t       m;
    last_due       = 0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      acc      = imem_req_valid && imem_req_ready;
      acc_addr = imem_addr;
      acc_cyc  = cyc;
      taken    = imem_rsp_valid;
      @(posedge clk);
      #1;
      if (taken && pend.size() > 0) void'(pend.pop_front());
      if (acc) begin
        due = acc_cyc + mem_lat + $urandom_range(0, mem_jit);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        m.due    = due;
        m.addr   = acc_addr;
        pend.push_back(m);
      end
      if (rst) begin
        pend.delete();
        last_due = 0;
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend[0].addr ^ XORV;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      imem_req_ready = ($urandom_range(0, 99) < mem_rdy_pct);
    end
  end

  // Monitor: compares every consumed instruction with the reference program stream.
  initial begin
    logic [31:0] exp_pc;
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    exp_pc    = RST_PC;
    prev_hold = 1'b0;
    prev_pc   = 32'd0;
    prev_instr = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc    = RST_PC;
        prev_hold = 1'b0;
        seg_q.delete();
      end else begin
        if (imem_req_valid) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (redirect_valid) chk1("req_in_redirect", imem_req_valid, 1'b0);
        if (prev_hold) begin
          chk1("hold_valid", instr_valid, 1'b1);
          chk("hold_pc", instr_pc, prev_pc);
          chk("hold_instr", instr, prev_instr);
        end
        if (instr_valid && instr_ready) begin
          chk("pop_pc", instr_pc, exp_pc);
          chk("pop_instr", instr, exp_pc ^ XORV);
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
        if (redirect_valid) begin
          chk1("seg_available", (seg_q.size() > 0), 1'b1);
          if (seg_q.size() > 0) exp_pc = seg_q.pop_front();
        end
        prev_hold  = instr_valid && !instr_ready && !redirect_valid;
        prev_pc    = instr_pc;
        prev_instr = instr;
      end
    end
  end

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    seg_q.push_back(tgt & 32'hFFFF_FFFC);
  endtask

  initial begin
    int  p0;
    logic ok;
    rst            = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);

    // First request, minimum latency, then full throughput across the pc wrap
    tick;
    rst         = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_addr, RST_PC);
    @(negedge clk);
    chk1("lat_n1_invalid", instr_valid, 1'b0);
    @(negedge clk);
    chk1("lat_n2_valid", instr_valid, 1'b1);
    chk("lat_n2_pc", instr_pc, RST_PC);
    @(posedge clk);
    p0 = pops;
    repeat (20) @(posedge clk);
    chk("throughput", 32'(pops - p0), 32'd20);

    // Back-pressure: queue fills, requests stop, head holds
    #1;
    instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk1("stall_valid", instr_valid, 1'b1);
    chk1("stall_no_req", imem_req_valid, 1'b0);
    chk("stall_inflight", 32'(pend.size()), 32'd0);
    tick;
    instr_ready = 1'b1;
    p0 = pops;
    repeat (10) tick;
    chk1("stall_release_progress", (pops - p0) >= 8, 1'b1);

    // Redirect with two requests in flight on a 3-cycle memory
    mem_lat = 3;
    repeat (8) tick;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick;
      #1;
      if (pend.size() == 2 && !imem_rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("drop_setup", ok, 1'b1);
    do_redirect(32'h0000_0103);
    tick;
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("drop_wait", ok, 1'b1);
    chk("drop_first_pc", instr_pc, 32'h0000_0100);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("drop_wait2", ok, 1'b1);
    chk("drop_second_pc", instr_pc, 32'h0000_0104);

    // Redirect coinciding with a response and a pop
    mem_lat = 1;
    repeat (6) tick;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      #1;
      if (imem_rsp_valid && instr_valid && instr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("coincide_setup", ok, 1'b1);
    do_redirect(32'h0000_2002);
    tick;
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("coincide_wait", ok, 1'b1);
    chk("coincide_next_pc", instr_pc, 32'h0000_2000);

    // Random traffic
    tick;
    mem_jit     = 3;
    mem_rdy_pct = 70;
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = 1'b0;
      if ($urandom_range(0, 39) == 0) do_redirect($urandom);
      tick;
    end
    redirect_valid = 1'b0;
    chk1("random_progress", (pops - p0) > 300, 1'b1);

    // Reset with a full queue
    mem_lat     = 2;
    mem_jit     = 0;
    mem_rdy_pct = 100;
    instr_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid && !imem_req_valid && pend.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("full_setup", ok, 1'b1);
    rst = 1'b1;
    #1;
    chk1("async_rst_valid", instr_valid, 1'b0);
    chk1("async_rst_req", imem_req_valid, 1'b0);
    chk("async_rst_pc", instr_pc, 32'd0);
    tick;
    tick;
    rst         = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk1("post_rst_req_valid", imem_req_valid, 1'b1);
    chk("post_rst_addr", imem_addr, RST_PC);
    p0 = pops;
    repeat (30) tick;
    chk1("post_rst_progress", (pops - p0) > 5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares",
             vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
